// File: rtl/noc_zero_unpad_pkg.sv
// Shared definitions for the zero-unpad stage: FSM states, settings-bus
// addresses and the keep-length width.
package noc_zero_unpad_pkg;

  localparam int KEEP_W = 16;

  localparam logic [7:0] SR_KEEP_ADDR = 8'd129;

  typedef enum logic {
    ST_KEEP = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  // Extract the keep length from a settings word; a zero length makes no
  // sense for a packet, so it is promoted to one sample.
  function automatic logic [KEEP_W-1:0] keepFromSetData(input logic [31:0] data);
    logic [KEEP_W-1:0] len;
    len = data[KEEP_W-1:0];
    return (len == '0) ? KEEP_W'(1) : len;
  endfunction

endpackage

// File: rtl/noc_zero_unpad_if.sv
// AXI-stream style handshake bundle used on both sides of the unpad stage.
interface noc_zero_unpad_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/noc_zero_unpad_nz_count.sv
// Saturating counter of non-zero samples found in the dropped pad region.
// The whole module only exists when ZERO_UNPAD_CHECK_EN is defined.
`ifdef ZERO_UNPAD_CHECK_EN
module zero_unpad_nz_count (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Count up on each flagged beat, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/noc_zero_unpad.sv
// noc_zero_unpad: forwards only the first keep_len samples of each padded
// packet, re-asserts tlast on the last kept sample and swallows the pad.
// Optional feature macro: ZERO_UNPAD_CHECK_EN (counts non-zero pad words).
module noc_zero_unpad
  import noc_zero_unpad_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] SR_KEEP = SR_KEEP_ADDR,
  parameter int         KEEP_L  = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  noc_zero_unpad_if.slave  i_axis,
  noc_zero_unpad_if.master o_axis,
  output logic [31:0]  nz_drop_cnt
);

  state_t             r_state;
  logic [KEEP_W-1:0]  r_cnt;
  logic [KEEP_W-1:0]  r_keep_len;
  logic [KEEP_W-1:0]  r_pend;
  logic               r_pend_vld;
  logic [WIDTH-1:0]   r_tdata;
  logic               r_tlast;
  logic               r_tvalid;

  logic               w_ready;
  logic               w_acc;
  logic               w_start;
  logic [KEEP_W-1:0]  w_keep;
  logic               w_cut;

  // While dropping, the pad never reaches the output, so input is always
  // taken; otherwise the single output stage gates the input.
  assign w_ready = ~reset & ((r_state == ST_DROP) | ~r_tvalid | o_axis.tready);
  assign w_acc   = i_axis.tvalid & w_ready;

  // A pending length takes effect at a packet boundary; the first beat of a
  // packet already uses the new length in the same cycle it is applied.
  assign w_start = (r_state == ST_KEEP) && (r_cnt == '0) && r_pend_vld;
  assign w_keep  = w_start ? r_pend : r_keep_len;
  assign w_cut   = (r_cnt == (w_keep - KEEP_W'(1)));

  assign i_axis.tready = w_ready;
  assign o_axis.tdata  = r_tdata;
  assign o_axis.tlast  = r_tlast;
  assign o_axis.tvalid = r_tvalid;

  // Main FSM with the registered output stage: keep beats until the cut
  // point or input tlast, then drop the rest of the padded packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_KEEP;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      if (r_tvalid && o_axis.tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      case (r_state)
        ST_KEEP: begin
          if (w_acc) begin
            r_tdata  <= i_axis.tdata;
            r_tvalid <= 1'b1;
            r_tlast  <= i_axis.tlast | w_cut;
            if (i_axis.tlast) begin
              r_cnt <= '0;
            end else if (w_cut) begin
              r_cnt   <= '0;
              r_state <= ST_DROP;
            end else begin
              r_cnt <= r_cnt + KEEP_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (w_acc && i_axis.tlast) begin
            r_state <= ST_KEEP;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_KEEP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Keep-length register: settings writes land in a pending slot and are
  // moved into the live length only between packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keep_len <= KEEP_W'(KEEP_L);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_start) begin
        r_keep_len <= r_pend;
        r_pend_vld <= 1'b0;
      end
      if (set_stb && (set_addr == SR_KEEP)) begin
        r_pend     <= keepFromSetData(set_data);
        r_pend_vld <= 1'b1;
      end
    end
  end

`ifdef ZERO_UNPAD_CHECK_EN
  logic w_nz_inc;

  assign w_nz_inc = w_acc && (r_state == ST_DROP) && (i_axis.tdata != '0);

  zero_unpad_nz_count u_nz_count (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_nz_inc),
    .o_count (nz_drop_cnt)
  );
`else
  assign nz_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_noc_zero_unpad.sv
// Directed testbench for noc_zero_unpad. Expected streams are built from the
// packet descriptions below and compared against what the monitor captures.
module tb_noc_zero_unpad;

  logic        clk;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] nz_drop_cnt;

  noc_zero_unpad_if #(.WIDTH(32)) inIf ();
  noc_zero_unpad_if #(.WIDTH(32)) outIf ();

  noc_zero_unpad #(
    .WIDTH   (32),
    .SR_KEEP (8'd129),
    .KEEP_L  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .i_axis      (inIf.slave),
    .o_axis      (outIf.master),
    .nz_drop_cnt (nz_drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] obsData[$];
  logic        obsLast[$];
  logic [31:0] expData[$];
  logic        expLast[$];

  bit randomReady = 1'b0;
  bit watchReady  = 1'b0;
  int lowReady    = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output ready driver: always ready unless random back-pressure is enabled.
  initial begin
    outIf.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      outIf.tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor on the falling edge: capture completed output transfers and
  // note any cycle where a presented input beat was refused.
  initial begin
    forever begin
      @(negedge clk);
      if (outIf.tvalid && outIf.tready) begin
        obsData.push_back(outIf.tdata);
        obsLast.push_back(outIf.tlast);
      end
      if (watchReady && inIf.tvalid && !inIf.tready) lowReady++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one beat and hold it until accepted, bounded by a cycle budget.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int guard;
    guard = 0;
    inIf.tdata  = data;
    inIf.tlast  = last;
    inIf.tvalid = 1'b1;
    @(negedge clk);
    while (!inIf.tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) checkOutput("tready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    inIf.tvalid = 1'b0;
    inIf.tlast  = 1'b0;
  endtask

  // Padded packet: samples 1..nData carry base+i, the rest are zero.
  task automatic sendPacket(input int base, input int total, input int nData);
    for (int i = 1; i <= total; i++) begin
      applyStimulus((i <= nData) ? 32'(base + i) : 32'd0, i == total);
    end
  endtask

  task automatic expectPacket(input int base, input int n);
    for (int i = 1; i <= n; i++) begin
      expData.push_back(32'(base + i));
      expLast.push_back(i == n);
    end
  endtask

  task automatic clearStreams();
    obsData.delete();
    obsLast.delete();
    expData.delete();
    expLast.delete();
  endtask

  task automatic writeKeep(input logic [31:0] value);
    set_addr = 8'd129;
    set_data = value;
    set_stb  = 1'b1;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the expected number of beats, then compare streams.
  task automatic checkStream(input string name);
    int cyc;
    int n;
    cyc = 0;
    while (obsData.size() < expData.size() && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput({name, "_beat_count"}, 32'(obsData.size()), 32'(expData.size()));
    n = (obsData.size() < expData.size()) ? obsData.size() : expData.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data[%0d]", name, i), obsData[i], expData[i]);
      checkOutput($sformatf("%s_last[%0d]", name, i), 32'(obsLast[i]), 32'(expLast[i]));
    end
  endtask

  // Directed test sequence.
  initial begin
    int tlastCount;
    reset       = 1'b1;
    set_stb     = 1'b0;
    set_addr    = 8'd0;
    set_data    = 32'd0;
    inIf.tdata  = 32'd0;
    inIf.tlast  = 1'b0;
    inIf.tvalid = 1'b0;

    @(negedge clk);
    checkOutput("reset_i_tready", 32'(inIf.tready), 32'd0);
    checkOutput("reset_o_tvalid", 32'(outIf.tvalid), 32'd0);
    checkOutput("reset_o_tlast", 32'(outIf.tlast), 32'd0);
    checkOutput("reset_o_tdata", outIf.tdata, 32'd0);
    checkOutput("reset_nz_drop_cnt", nz_drop_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] test 1: two 32-sample padded packets, continuous flow");
    clearStreams();
    lowReady   = 0;
    watchReady = 1'b1;
    sendPacket(0, 32, 20);
    sendPacket(0, 32, 20);
    watchReady = 1'b0;
    expectPacket(0, 20);
    expectPacket(0, 20);
    checkStream("t1");
    checkOutput("t1_ready_low_cycles", 32'(lowReady), 32'd0);

    $display("[TB] test 2: short packet, exact-length packet, then long packet");
    clearStreams();
    sendPacket(32'h100, 8, 8);
    sendPacket(32'h200, 20, 20);
    sendPacket(32'h300, 8, 8);
    sendPacket(32'h400, 32, 20);
    expectPacket(32'h100, 8);
    expectPacket(32'h200, 20);
    expectPacket(32'h300, 8);
    expectPacket(32'h400, 20);
    checkStream("t2");

    $display("[TB] test 3: random output back-pressure, three packets");
    clearStreams();
    randomReady = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      sendPacket(p * 256, 32, 20);
      expectPacket(p * 256, 20);
    end
    checkStream("t3");
    randomReady = 1'b0;
    tlastCount = 0;
    foreach (obsLast[i]) if (obsLast[i]) tlastCount++;
    checkOutput("t3_tlast_count", 32'(tlastCount), 32'd3);

    $display("[TB] test 4: keep length change mid-packet");
    clearStreams();
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        set_addr = 8'd129;
        set_data = 32'd5;
        set_stb  = 1'b1;
      end
      applyStimulus((i <= 20) ? 32'(32'h500 + i) : 32'd0, i == 32);
      set_stb = 1'b0;
    end
    sendPacket(32'h600, 32, 20);
    expectPacket(32'h500, 20);
    expectPacket(32'h600, 5);
    checkStream("t4");

    $display("[TB] test 4b: keep length written as zero behaves as one");
    clearStreams();
    writeKeep(32'h0001_0000);
    sendPacket(32'h700, 3, 3);
    expectPacket(32'h700, 1);
    checkStream("t4b");
    writeKeep(32'd20);

    $display("[TB] test 5: reset while dropping pad");
    for (int i = 1; i <= 25; i++) begin
      applyStimulus((i <= 20) ? 32'(32'h800 + i) : 32'd0, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_i_tready", 32'(inIf.tready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    clearStreams();
    sendPacket(32'h900, 32, 20);
    expectPacket(32'h900, 20);
    checkStream("t5");

    $display("[TB] test 6: non-zero words in the pad region");
    clearStreams();
    for (int i = 1; i <= 32; i++) begin
      logic [31:0] d;
      d = (i <= 20) ? 32'(32'hA00 + i) : 32'd0;
      if (i == 22) d = 32'hDEAD;
      if (i == 25) d = 32'hBEEF;
      if (i == 30) d = 32'h1;
      applyStimulus(d, i == 32);
    end
    expectPacket(32'hA00, 20);
    checkStream("t6");
`ifdef ZERO_UNPAD_CHECK_EN
    checkOutput("t6_nz_drop_cnt", nz_drop_cnt, 32'd3);
`else
    checkOutput("t6_nz_drop_cnt", nz_drop_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
